// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: PRGA state encoding, byte widths and the Moore output
// decoder used to precompute the registered outputs of the decrypt FSM.
package rc4_pkg;

    localparam int S_ADDR_W = 8;
    localparam int BYTE_W   = 8;
    localparam int S_SIZE   = 256;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ADDR_SI = 4'd1,
        CAP_SI  = 4'd2,
        ADDR_SJ = 4'd3,
        CAP_SJ  = 4'd4,
        WR_I    = 4'd5,
        WR_J    = 4'd6,
        ADDR_F  = 4'd7,
        CAP_F   = 4'd8,
        WR_OUT  = 4'd9,
        NEXT    = 4'd10,
        DONE    = 4'd11
    } prga_state_t;

    typedef struct packed {
        logic [S_ADDR_W-1:0] s_address;
        logic [BYTE_W-1:0]   s_data;
        logic                s_wren;
        logic [S_ADDR_W-1:0] rom_address;
        logic [S_ADDR_W-1:0] out_address;
        logic [BYTE_W-1:0]   out_data;
        logic                out_wren;
        logic                busy;
        logic                finish;
    } prga_out_t;

    // Outputs that a given state and register set present to the memories.
    function automatic prga_out_t decode_outputs(
        input prga_state_t       st,
        input logic [BYTE_W-1:0] i,
        input logic [BYTE_W-1:0] j,
        input logic [BYTE_W-1:0] k,
        input logic [BYTE_W-1:0] si,
        input logic [BYTE_W-1:0] sj,
        input logic [BYTE_W-1:0] f,
        input logic [BYTE_W-1:0] enc
    );
        prga_out_t o;
        o = '0;
        if ((st == IDLE) || (st == DONE)) begin
            o.busy   = 1'b0;
            o.finish = (st == DONE);
        end else begin
            o.busy        = 1'b1;
            o.finish      = 1'b0;
            o.rom_address = k;
        end
        case (st)
            ADDR_SI: o.s_address = i;
            ADDR_SJ: o.s_address = j;
            WR_I: begin
                o.s_address = i;
                o.s_data    = sj;
                o.s_wren    = 1'b1;
            end
            WR_J: begin
                o.s_address = j;
                o.s_data    = si;
                o.s_wren    = 1'b1;
            end
            ADDR_F:  o.s_address = si + sj;
            WR_OUT: begin
                o.out_address = k;
                o.out_data    = f ^ enc;
                o.out_wren    = 1'b1;
            end
            default: o.s_wren = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/prga_decrypt_fsm.sv
// RC4 pseudo-random generation over S, XOR with message_rom and write of the
// plaintext into decrypted_ram; ten cycles per message byte.
import rc4_pkg::*;

module prga_decrypt_fsm #(
    parameter int MSG_LEN = 32
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic                start,
    output logic [S_ADDR_W-1:0] s_address,
    output logic [BYTE_W-1:0]   s_data,
    output logic                s_wren,
    input  logic [BYTE_W-1:0]   s_q,
    output logic [S_ADDR_W-1:0] rom_address,
    input  logic [BYTE_W-1:0]   rom_q,
    output logic [S_ADDR_W-1:0] out_address,
    output logic [BYTE_W-1:0]   out_data,
    output logic                out_wren,
    output logic                busy,
    output logic                finish
);

    localparam logic [BYTE_W-1:0] K_LAST = BYTE_W'(MSG_LEN - 1);

    prga_state_t       state_q, state_d;
    logic [BYTE_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [BYTE_W-1:0] si_q, si_d, sj_q, sj_d, f_q, f_d, enc_q, enc_d;
    prga_out_t         out_q, out_d;

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        enc_d   = enc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ADDR_SI;
                    i_d     = 8'd1;
                    j_d     = 8'd0;
                    k_d     = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR_SI: state_d = CAP_SI;
            CAP_SI: begin
                si_d    = s_q;
                j_d     = j_q + s_q;
                enc_d   = rom_q;
                state_d = ADDR_SJ;
            end
            ADDR_SJ: state_d = CAP_SJ;
            CAP_SJ: begin
                sj_d    = s_q;
                state_d = WR_I;
            end
            WR_I:    state_d = WR_J;
            WR_J:    state_d = ADDR_F;
            ADDR_F:  state_d = CAP_F;
            CAP_F: begin
                f_d     = s_q;
                state_d = WR_OUT;
            end
            WR_OUT:  state_d = NEXT;
            NEXT: begin
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 8'd1;
                    i_d     = i_q + 8'd1;
                    state_d = ADDR_SI;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded one cycle early so they leave the block from flops.
    always_comb begin
        out_d = decode_outputs(state_d, i_d, j_d, k_d, si_d, sj_d, f_d, enc_d);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            f_q     <= 8'd0;
            enc_q   <= 8'd0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            enc_q   <= enc_d;
            out_q   <= out_d;
        end
    end

    assign s_address   = out_q.s_address;
    assign s_data      = out_q.s_data;
    assign s_wren      = out_q.s_wren;
    assign rom_address = out_q.rom_address;
    assign out_address = out_q.out_address;
    assign out_data    = out_q.out_data;
    assign out_wren    = out_q.out_wren;
    assign busy        = out_q.busy;
    assign finish      = out_q.finish;

endmodule

// File: tb/tb_prga_decrypt_fsm.sv
// Bench for prga_decrypt_fsm: three instances (MSG_LEN 4, 32, 256) with
// behavioural memories, checked against a software RC4 PRGA model.
module tb_prga_decrypt_fsm;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       reset_n;
    logic       start_a    [3];
    logic [7:0] s_addr_a   [3];
    logic [7:0] s_data_a   [3];
    logic       s_wren_a   [3];
    logic [7:0] s_q_a      [3];
    logic [7:0] rom_addr_a [3];
    logic [7:0] rom_q_a    [3];
    logic [7:0] out_addr_a [3];
    logic [7:0] out_data_a [3];
    logic       out_wren_a [3];
    logic       busy_a     [3];
    logic       finish_a   [3];

    logic [7:0] s_mem   [3][256];
    logic [7:0] rom_mem [3][256];
    logic [7:0] out_mem [3][256];
    logic [7:0] init_s  [256];
    logic [7:0] init_rom[256];
    logic       load    [3];

    logic [7:0] m_s     [256];
    logic [7:0] exp_out [256];
    logic [7:0] plain   [256];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        prga_decrypt_fsm #(.MSG_LEN(g == 0 ? 4 : (g == 1 ? 32 : 256))) u_dut (
            .CLOCK_50   (clk),
            .reset_n    (reset_n),
            .start      (start_a[g]),
            .s_address  (s_addr_a[g]),
            .s_data     (s_data_a[g]),
            .s_wren     (s_wren_a[g]),
            .s_q        (s_q_a[g]),
            .rom_address(rom_addr_a[g]),
            .rom_q      (rom_q_a[g]),
            .out_address(out_addr_a[g]),
            .out_data   (out_data_a[g]),
            .out_wren   (out_wren_a[g]),
            .busy       (busy_a[g]),
            .finish     (finish_a[g])
        );
    end

    // Synchronous 1-cycle-latency memories; load copies the init images in.
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (load[g]) begin
                s_mem[g]   <= init_s;
                rom_mem[g] <= init_rom;
                out_mem[g] <= '{default: 8'hEE};
            end else begin
                s_q_a[g]   <= s_mem[g][s_addr_a[g]];
                rom_q_a[g] <= rom_mem[g][rom_addr_a[g]];
                if (s_wren_a[g]) s_mem[g][s_addr_a[g]] <= s_data_a[g];
                if (out_wren_a[g]) out_mem[g][out_addr_a[g]] <= out_data_a[g];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Software RC4 PRGA over init_s/init_rom.
    task automatic model(input int len);
        int i, j, t;
        for (int x = 0; x < 256; x++) m_s[x] = init_s[x];
        i = 0;
        j = 0;
        for (int n = 0; n < len; n++) begin
            i = (i + 1) % 256;
            j = (j + int'(m_s[i])) % 256;
            t = int'(m_s[i]);
            m_s[i] = m_s[j];
            m_s[j] = 8'(t);
            exp_out[n] = m_s[(int'(m_s[i]) + int'(m_s[j])) % 256] ^ init_rom[n];
        end
    endtask

    task automatic identity_s();
        for (int x = 0; x < 256; x++) init_s[x] = 8'(x);
    endtask

    task automatic ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
        logic [7:0] key [3];
        int j, t;
        key[0] = k0; key[1] = k1; key[2] = k2;
        identity_s();
        j = 0;
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(init_s[i]) + int'(key[i % 3])) % 256;
            t = int'(init_s[i]);
            init_s[i] = init_s[j];
            init_s[j] = 8'(t);
        end
    endtask

    task automatic shuffle_s();
        int j, t;
        identity_s();
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = int'(init_s[i]);
            init_s[i] = init_s[j];
            init_s[j] = 8'(t);
        end
    endtask

    task automatic load_mem(input int g);
        @(negedge clk);
        load[g] = 1'b1;
        @(negedge clk);
        load[g] = 1'b0;
    endtask

    // One complete decrypt on instance g, checking timing, handshake and data.
    task automatic run(input int g, input int len, input bit hold, input int glitch_at,
                       input string tag);
        int cnt, nw, last_w, derr, serr;
        bit ok_int, ok_addr, ok_busy;
        load_mem(g);
        model(len);
        start_a[g] = 1'b1;
        @(negedge clk);
        cnt = 1;
        if (!hold) start_a[g] = 1'b0;
        nw = 0; last_w = -1; ok_int = 1'b1; ok_addr = 1'b1; ok_busy = 1'b1;
        while (!finish_a[g] && cnt < 10 * len + 50) begin
            if (cnt == glitch_at) start_a[g] = 1'b1;
            else if (!hold) start_a[g] = 1'b0;
            if (!busy_a[g]) ok_busy = 1'b0;
            if (out_wren_a[g]) begin
                if (last_w >= 0 && cnt - last_w != 10) ok_int = 1'b0;
                if (out_addr_a[g] != 8'(nw)) ok_addr = 1'b0;
                last_w = cnt;
                nw++;
            end
            @(negedge clk);
            cnt++;
        end
        if (!hold) start_a[g] = 1'b0;
        chk({tag, " finish_latency"}, cnt, 10 * len + 1);
        chk({tag, " finish_high"}, {31'd0, finish_a[g]}, 32'd1);
        chk({tag, " done_busy"}, {31'd0, busy_a[g]}, 32'd0);
        chk({tag, " done_wren"}, {30'd0, s_wren_a[g], out_wren_a[g]}, 32'd0);
        chk({tag, " wren_count"}, nw, len);
        chk({tag, " wren_spacing"}, {31'd0, ok_int}, 32'd1);
        chk({tag, " out_addr_seq"}, {31'd0, ok_addr}, 32'd1);
        chk({tag, " busy_in_run"}, {31'd0, ok_busy}, 32'd1);
        if (hold) begin
            repeat (3) @(negedge clk);
            chk({tag, " finish_held"}, {31'd0, finish_a[g]}, 32'd1);
            start_a[g] = 1'b0;
        end
        @(negedge clk);
        chk({tag, " finish_drop"}, {30'd0, finish_a[g], busy_a[g]}, 32'd0);
        derr = 0;
        serr = 0;
        for (int n = 0; n < len; n++) if (out_mem[g][n] !== exp_out[n]) derr++;
        for (int x = 0; x < 256; x++) if (s_mem[g][x] !== m_s[x]) serr++;
        chk({tag, " plaintext_errs"}, derr, 0);
        chk({tag, " final_s_errs"}, serr, 0);
        if (len < 256) chk({tag, " no_write_past_end"}, {24'd0, out_mem[g][len]}, 32'hEE);
    endtask

    typedef struct {
        logic [7:0] rom_fill;
        logic [7:0] exp [4];
    } vec_t;

    initial begin
        vec_t vecs [3];
        int   g, len, ga;
        bit   hold;

        vecs[0] = '{rom_fill: 8'h00, exp: '{8'h02, 8'h05, 8'h07, 8'h0D}};
        vecs[1] = '{rom_fill: 8'hFF, exp: '{8'hFD, 8'hFA, 8'hF8, 8'hF2}};
        vecs[2] = '{rom_fill: 8'h5A, exp: '{8'h58, 8'h5F, 8'h5D, 8'h57}};

        reset_n = 1'b0;
        for (int x = 0; x < 3; x++) begin
            start_a[x] = 1'b0;
            load[x]    = 1'b0;
        end
        identity_s();
        for (int x = 0; x < 256; x++) init_rom[x] = 8'h00;
        repeat (3) @(negedge clk);
        for (int x = 0; x < 3; x++) begin
            chk($sformatf("reset_outputs%0d", x),
                {s_addr_a[x], rom_addr_a[x], out_addr_a[x], 8'd0}, 32'd0);
            chk($sformatf("reset_ctrl%0d", x),
                {28'd0, s_wren_a[x], out_wren_a[x], busy_a[x], finish_a[x]}, 32'd0);
        end
        reset_n = 1'b1;

        // Identity S, MSG_LEN=4, fixed ROM fills with hand-derived plaintext.
        for (int v = 0; v < 3; v++) begin
            identity_s();
            for (int x = 0; x < 256; x++) init_rom[x] = vecs[v].rom_fill;
            run(0, 4, 1'b0, -1, $sformatf("vec%0d", v));
            for (int n = 0; n < 4; n++)
                chk($sformatf("vec%0d byte%0d", v, n), {24'd0, out_mem[0][n]},
                    {24'd0, vecs[v].exp[n]});
        end
        chk("ident S[2]", {24'd0, s_mem[0][2]}, 32'h03);
        chk("ident S[3]", {24'd0, s_mem[0][3]}, 32'h05);
        chk("ident S[5]", {24'd0, s_mem[0][5]}, 32'h02);

        // Full chain: key 00_02_49, ciphertext built from the reference keystream.
        ksa(8'h00, 8'h02, 8'h49);
        for (int x = 0; x < 256; x++) init_rom[x] = 8'h00;
        model(32);
        for (int n = 0; n < 32; n++) begin
            plain[n]    = 8'($urandom_range(32, 126));
            init_rom[n] = plain[n] ^ exp_out[n];
        end
        run(1, 32, 1'b0, -1, "key_chain");
        chk("key_chain plain0", {24'd0, out_mem[1][0]}, {24'd0, plain[0]});
        chk("key_chain plain31", {24'd0, out_mem[1][31]}, {24'd0, plain[31]});

        // Reset in WR_J of byte 10, then re-init S and rerun.
        load_mem(1);
        start_a[1] = 1'b1;
        @(negedge clk);
        start_a[1] = 1'b0;
        repeat (105) @(negedge clk);
        chk("pre_reset in WR_J", {31'd0, s_wren_a[1]}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_reset ctrl", {28'd0, s_wren_a[1], out_wren_a[1], busy_a[1], finish_a[1]}, 32'd0);
        chk("mid_reset addr", {24'd0, s_addr_a[1]}, 32'd0);
        reset_n = 1'b1;
        run(1, 32, 1'b0, -1, "after_reset");

        // Held start, and a start pulse while busy.
        run(1, 32, 1'b1, -1, "held_start");
        run(1, 32, 1'b0, 57, "busy_pulse");

        // MSG_LEN=256 on identity S: i wraps, last address 0xFF.
        identity_s();
        for (int x = 0; x < 256; x++) init_rom[x] = 8'h00;
        run(2, 256, 1'b0, -1, "len256");

        // Randomized permutations, ciphertexts and start styles.
        for (int r = 0; r < 6; r++) begin
            g    = int'($urandom_range(0, 2));
            len  = (g == 0) ? 4 : ((g == 1) ? 32 : 256);
            hold = 1'($urandom_range(0, 1));
            ga   = int'($urandom_range(2, 10 * len - 5));
            shuffle_s();
            for (int x = 0; x < 256; x++) init_rom[x] = 8'($urandom_range(0, 255));
            run(g, len, hold, ga, $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prga_decrypt_fsm.md
Name: prga_decrypt_fsm

Overview:
- Consumer side of the S-array memory: reads and swaps S after the key-scheduling permutation finishes.
- Runs the RC4 pseudo-random generation algorithm over S.
- XORs each keystream byte with the next encrypted byte from message_rom and writes the plaintext byte to decrypted_ram.
- Sits beside the identity and permutation FSMs; the top-level controller hands it the s_memory port after the permutation stage reports finish.

Parameters:
- MSG_LEN, 32, number of message bytes processed; legal range 1..256.

Ports:
- CLOCK_50  in  1  clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  level or pulse; sampled only in IDLE.
- s_address  out  8  s_memory address.
- s_data  out  8  s_memory write data.
- s_wren  out  1  s_memory write enable.
- s_q  in  8  s_memory read data.
- rom_address  out  8  message_rom address (k).
- rom_q  in  8  encrypted byte.
- out_address  out  8  decrypted_ram address (k).
- out_data  out  8  plaintext byte.
- out_wren  out  1  decrypted_ram write enable.
- busy  out  1  high in every state except IDLE and DONE.
- finish  out  1  high only in DONE.

Behaviour:
- Reset is synchronous, active-low, on CLOCK_50. On reset: state=IDLE, i=0, j=0, k=0, si=sj=f=enc=0.
- Outputs are Moore-decoded from state and registers. In IDLE/DONE all addresses are 0, all data are 0, s_wren=out_wren=0, busy=0.
- Memory timing: s_memory and message_rom have 1-cycle read latency. An address driven in cycle N is valid on q in cycle N+1. No read and write to s_memory ever occur in the same cycle.
- States and per-state actions:
  - IDLE: if start, then i<=1, j<=0, k<=0, go ADDR_SI.
  - ADDR_SI: s_address=i; rom_address=k (held stable in every non-IDLE state).
  - CAP_SI: si<=s_q; j<=j+s_q (mod 256); enc<=rom_q.
  - ADDR_SJ: s_address=j.
  - CAP_SJ: sj<=s_q.
  - WR_I: s_address=i, s_data=sj, s_wren=1.
  - WR_J: s_address=j, s_data=si, s_wren=1.
  - ADDR_F: s_address=si+sj (mod 256).
  - CAP_F: f<=s_q.
  - WR_OUT: out_address=k, out_data=f^enc, out_wren=1.
  - NEXT: if k==MSG_LEN-1 go DONE; else k<=k+1, i<=i+1 (mod 256), go ADDR_SI.
  - DONE: finish=1; if start==0 go IDLE, else stay.
- Throughput: exactly 10 cycles per byte. The first DONE cycle is 10*MSG_LEN+1 cycles after the edge that sampled start in IDLE.
- Pulse start: finish is high for exactly 1 cycle. Held start: finish stays high until start drops.
- start asserted while busy is ignored.
- i==j: both writes target the same address with the same value (si==sj); no special handling.
- i wraps 255->0 when MSG_LEN=256; k never exceeds MSG_LEN-1; no write beyond out_address MSG_LEN-1.
- Reset mid-run: next cycle is IDLE with all wren=0. S is left partially swapped; the controller must rerun identity and permutation before restarting.
- All arithmetic is 8-bit with natural wrap; no saturation.

Decomposition:
- Shared package rc4_pkg holds:
  - enum prga_state_t (IDLE, ADDR_SI, CAP_SI, ADDR_SJ, CAP_SJ, WR_I, WR_J, ADDR_F, CAP_F, WR_OUT, NEXT, DONE);
  - localparams S_ADDR_W=8, BYTE_W=8, S_SIZE=256.
- The block is a single FSM plus datapath registers. No sub-module is natural; the top-level controller owns the s_memory mux.

Test Plan:
- Identity S (S[x]=x), MSG_LEN=4, ROM all 0x00, start pulse -> decrypted_ram[0..3] = 0x02,0x05,0x07,0x0D. After the run, S[2]=0x03, S[3]=0x05, S[5]=0x02.
- Same as above with ROM all 0xFF -> outputs 0xFD,0xFA,0xF8,0xF2; out_wren high exactly 4 cycles, one per 10-cycle byte slot.
- Full chain with key 00_02_49, MSG_LEN=32, ROM loaded from the golden model ciphertext -> all 32 bytes match the software RC4 model; first finish exactly 321 cycles after start sampled.
- Reset asserted during byte 10 (in WR_J) -> next cycle IDLE with s_wren=out_wren=busy=finish=0. Re-init S, restart -> correct output for all 32 bytes.
- start held high through the run -> finish stays high in DONE; drop start -> IDLE next cycle. A start pulse while busy causes no restart or state glitch.
- MSG_LEN=256, identity S -> i wraps 255->0 without error; last out_address=0xFF; finish after 2561 cycles; no out_wren after byte 255.
